sop_logic_array: RTL and testbench

- Parametrised, pipelined sum-of-products (AND-OR / AND-OR-INVERT) gate array.
- CHANNELS independent outputs. Each output is the OR of GROUPS product terms, and each product term is a TERM_W-input AND.
- Each channel has a runtime group-enable mask and an invert mode.
- Operands enter and results leave through valid/ready handshakes, so the block drops into streaming datapaths in place of fixed-function AND-OR glue chips.

---
 rtl/sop_logic_array.sv | 112 +++++++++++
 tb/tb_sop_logic_array.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sop_logic_array.sv
// Pipelined sum-of-products (AND-OR / AND-OR-INVERT) array with per-channel mask and invert.
// Define SOP_HIT_CNT_EN to add hit_cnt, a saturating count of nonzero output transfers.
module sop_logic_array #(
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned GROUPS   = 2,
    parameter int unsigned TERM_W   = 3,
    parameter int unsigned CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
`ifdef SOP_HIT_CNT_EN
    ,
    parameter int unsigned CNT_W    = 16
`endif
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [CHANNELS*GROUPS*TERM_W-1:0]   in_data,
    input  logic                                cfg_we,
    input  logic [CH_W-1:0]                     cfg_ch,
    input  logic [GROUPS-1:0]                   cfg_mask,
    input  logic                                cfg_inv,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [CHANNELS-1:0]                 out_y
`ifdef SOP_HIT_CNT_EN
    ,
    output logic [CNT_W-1:0]                    hit_cnt
`endif
);
    localparam int unsigned NTERM = CHANNELS * GROUPS;

    logic [NTERM-1:0]    mask_q;
    logic [CHANNELS-1:0] inv_q;
    logic                s1_valid_q;
    logic [NTERM-1:0]    s1_term_q;
    logic [CHANNELS-1:0] s1_inv_q;
    logic                s2_valid_q;
    logic [CHANNELS-1:0] y_q;

    logic                adv1;
    logic                adv2;
    logic                cfg_hit;
    logic [NTERM-1:0]    term_d;
    logic [CHANNELS-1:0] y_d;

    assign adv2      = !s2_valid_q || out_ready;
    assign adv1      = !s1_valid_q || adv2;
    assign in_ready  = adv1;
    assign out_valid = s2_valid_q;
    assign out_y     = y_q;
    assign cfg_hit   = cfg_we && (32'(cfg_ch) < CHANNELS);

    // Masking happens at capture so in-flight beats keep the config they were accepted with.
    always_comb begin
        term_d = '0;
        for (int unsigned i = 0; i < NTERM; i++) begin
            term_d[i] = (&in_data[i*TERM_W +: TERM_W]) & mask_q[i];
        end
    end

    always_comb begin
        y_d = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            y_d[c] = (|s1_term_q[c*GROUPS +: GROUPS]) ^ s1_inv_q[c];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mask_q     <= '1;
            inv_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_term_q  <= '0;
            s1_inv_q   <= '0;
            s2_valid_q <= 1'b0;
            y_q        <= '0;
        end else begin
            if (adv1) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    s1_term_q <= term_d;
                    s1_inv_q  <= inv_q;
                end
            end
            if (adv2) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    y_q <= y_d;
                end
            end
            if (cfg_hit) begin
                mask_q[cfg_ch*GROUPS +: GROUPS] <= cfg_mask;
                inv_q[cfg_ch]                   <= cfg_inv;
            end
        end
    end

`ifdef SOP_HIT_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    assign hit_cnt = cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (s2_valid_q && out_ready && (|y_q) && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_sop_logic_array.sv
// Bench for sop_logic_array: vector table plus hand sequences, checked through an in-order
// scoreboard of expected out_y values.
`timescale 1ns/1ps
module tb_sop_logic_array;
    localparam int CH = 2;
    localparam int GR = 2;
    localparam int TW = 3;
    localparam int DW = CH * GR * TW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          cfg_we = 1'b0;
    logic [0:0]    cfg_ch = 1'b0;
    logic [GR-1:0] cfg_mask = '1;
    logic          cfg_inv = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [CH-1:0] out_y;
`ifdef SOP_HIT_CNT_EN
    logic [1:0]    hit_cnt;
`endif

    sop_logic_array #(
        .CHANNELS(CH),
        .GROUPS  (GR),
        .TERM_W  (TW)
`ifdef SOP_HIT_CNT_EN
        ,
        .CNT_W   (2)
`endif
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .cfg_we   (cfg_we),
        .cfg_ch   (cfg_ch),
        .cfg_mask (cfg_mask),
        .cfg_inv  (cfg_inv),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_y    (out_y)
`ifdef SOP_HIT_CNT_EN
        ,
        .hit_cnt  (hit_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          we;
        logic [0:0]    ch;
        logic [GR-1:0] mask;
        logic          inv;
        logic          valid;
        logic [DW-1:0] data;
        logic [CH-1:0] exp;
    } row_t;

    logic [CH-1:0] sb[$];
    logic [CH-1:0] cur_exp = '0;
    logic [CH-1:0] mon_exp;
    int            errors = 0;
    int            checks = 0;
    int            transfers = 0;

    // Scoreboard: push on accept, pop/compare on output transfer; reset discards in-flight beats.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                transfers++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: got out_y=%b, required no beat", out_y);
                end else begin
                    mon_exp = sb.pop_front();
                    if (out_y !== mon_exp) begin
                        errors++;
                        $display("FAIL sb_out_y: got %b, required %b", out_y, mon_exp);
                    end
                end
            end
            if (in_valid && in_ready) sb.push_back(cur_exp);
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, got, want);
        end
    endtask

    task automatic apply_row(input row_t r, input int idx);
        int n = 0;
        cfg_we = r.we; cfg_ch = r.ch; cfg_mask = r.mask; cfg_inv = r.inv;
        in_valid = r.valid; in_data = r.data; cur_exp = r.exp;
        @(negedge clk);
        while (in_valid && !in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            checks++;
            errors++;
            $display("FAIL row%0d_accept: got no accept, required accept within 20 cycles", idx);
        end
        @(posedge clk); #1;
        cfg_we = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        out_ready = 1'b1;
        @(negedge clk);
        while ((sb.size() != 0 || out_valid) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(sb.size()), 32'd0);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; in_valid = 1'b1; in_data = '1;
        @(posedge clk); #1;
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    endtask

    function automatic logic [CH-1:0] model(input logic [DW-1:0] d, input logic [CH*GR-1:0] m,
                                            input logic [CH-1:0] inv);
        logic [CH-1:0] y;
        logic          any;
        for (int c = 0; c < CH; c++) begin
            any = 1'b0;
            for (int g = 0; g < GR; g++) begin
                if (m[c*GR+g] && (d[(c*GR+g)*TW +: TW] == '1)) any = 1'b1;
            end
            y[c] = any ^ inv[c];
        end
        return y;
    endfunction

    row_t rows[14];
    row_t r;

    initial begin
        int            t0;
        int            sent;
        int            guard;
        logic          acc;
        logic [DW-1:0] d;

        rows[0]  = '{1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 12'h038, 2'b01};
        rows[1]  = '{1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 12'h1C7, 2'b11};
        rows[2]  = '{1'b1, 1'b1, 2'b11, 1'b1, 1'b1, 12'h000, 2'b00}; // old config applies
        rows[3]  = '{1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 12'hE00, 2'b00};
        rows[4]  = '{1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 12'h000, 2'b10};
        rows[5]  = '{1'b1, 1'b0, 2'b01, 1'b0, 1'b1, 12'h038, 2'b11}; // old mask applies
        rows[6]  = '{1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 12'h038, 2'b10};
        rows[7]  = '{1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 12'h007, 2'b11};
        rows[8]  = '{1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 12'h000, 2'b00};
        rows[9]  = '{1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 12'hFFF, 2'b01};
        rows[10] = '{1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 12'h000, 2'b11};
        rows[11] = '{1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 12'h000, 2'b00};
        rows[12] = '{1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 12'h000, 2'b00};
        rows[13] = '{1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 12'h1C0, 2'b10};

        // Reset held with a valid beat offered
        rst_n = 1'b0; in_valid = 1'b1; in_data = '1; out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("rst_out_valid", 32'(out_valid), 32'd0);
            check("rst_out_y", 32'(out_y), 32'd0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        repeat (4) begin
            @(negedge clk);
            check("rst_no_phantom", 32'(out_valid), 32'd0);
        end

        @(posedge clk); #1;
        foreach (rows[i]) apply_row(rows[i], i);
        wait_drain("table_drain");

        // Latency: accept in cycle 0, out_valid in cycle 2
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = 12'h038; cur_exp = 2'b01;
        @(negedge clk);
        check("lat_accept", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("lat_cycle1_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("lat_cycle2_valid", 32'(out_valid), 32'd1);
        check("lat_cycle2_y", 32'(out_y), 32'h1);
        wait_drain("lat_drain");

        // Backpressure: two beats fill the pipe, third stalls
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b1; in_data = 12'h007; cur_exp = 2'b01;
        @(negedge clk);
        check("bp_acc0", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_data = 12'h1C0; cur_exp = 2'b10;
        @(negedge clk);
        check("bp_acc1", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_data = 12'h000; cur_exp = 2'b00;
        repeat (3) begin
            @(negedge clk);
            check("bp_stall_ready", 32'(in_ready), 32'd0);
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_y", 32'(out_y), 32'h1);
            @(posedge clk); #1;
        end
        t0 = transfers;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_acc2", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_drain("bp_drain");
        check("bp_transfers", 32'(transfers - t0), 32'd3);

        // Random stream with random stalls; ch0 uses g1 only, ch1 inverted
        r = '{1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 12'h000, 2'b00};
        apply_row(r, 100);
        r = '{1'b1, 1'b1, 2'b11, 1'b1, 1'b0, 12'h000, 2'b00};
        apply_row(r, 101);
        t0 = transfers;
        sent = 0;
        guard = 0;
        while (sent < 40 && guard < 2000) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (!in_valid && $urandom_range(0, 3) != 0) begin
                for (int k = 0; k < CH * GR; k++) begin
                    d[k*TW +: TW] = ($urandom_range(0, 1) != 0) ? 3'b111 : 3'($urandom);
                end
                in_data = d;
                cur_exp = model(d, 4'b1110, 2'b10);
                in_valid = 1'b1;
            end
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) begin
                in_valid = 1'b0;
                sent++;
            end
            guard++;
        end
        check("rand_sent", 32'(sent), 32'd40);
        wait_drain("rand_drain");
        check("rand_transfers", 32'(transfers - t0), 32'd40);

        // Reset mid-stream with a full pipe
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b1; in_data = 12'h1C7; cur_exp = 2'b11;
        @(negedge clk);
        @(posedge clk); #1;
        in_data = 12'h038;
        @(negedge clk);
        pulse_reset();
        @(negedge clk);
        check("mrst_out_valid", 32'(out_valid), 32'd0);
        check("mrst_in_ready", 32'(in_ready), 32'd1);
`ifdef SOP_HIT_CNT_EN
        check("mrst_hit_cnt", 32'(hit_cnt), 32'd0);
`endif
        repeat (3) begin
            @(negedge clk);
            check("mrst_no_phantom", 32'(out_valid), 32'd0);
        end
        // Config back to defaults: ch1 no longer inverted
        @(posedge clk); #1;
        r = '{1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 12'hE00, 2'b10};
        apply_row(r, 200);
        r = '{1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 12'h038, 2'b01};
        apply_row(r, 201);
        wait_drain("mrst_cfg_drain");

`ifdef SOP_HIT_CNT_EN
        pulse_reset();
        r = '{1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 12'h007, 2'b01};
        repeat (2) apply_row(r, 300);
        wait_drain("hit_drain0");
        check("hit_cnt_2", 32'(hit_cnt), 32'd2);
        @(posedge clk); #1;
        r = '{1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 12'h000, 2'b00};
        apply_row(r, 301);
        wait_drain("hit_drain1");
        check("hit_cnt_zero_beat", 32'(hit_cnt), 32'd2);
        @(posedge clk); #1;
        r = '{1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 12'h007, 2'b01};
        repeat (3) apply_row(r, 302);
        wait_drain("hit_drain2");
        check("hit_cnt_sat", 32'(hit_cnt), 32'd3);
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b1; in_data = 12'h007; cur_exp = 2'b01;
        @(negedge clk);
        pulse_reset();
        @(negedge clk);
        check("hit_rst_cnt", 32'(hit_cnt), 32'd0);
        check("hit_rst_valid", 32'(out_valid), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: got no finish, required finish within 1 ms");
        $fatal(1);
    end

endmodule
